// File: rtl/rv_core_pkg.sv
// Shared front-end definitions: fetch FSM encoding and RISC-V instruction constants.
package rv_core_pkg;

  localparam int unsigned RV_ILEN    = 32;
  localparam int unsigned RV_PC_STEP = 4;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_FLUSH = 2'd2
  } fru_state_e;

endpackage

// File: rtl/fru_fifo2.sv
// Two-entry first-word-fall-through FIFO with synchronous flush.
// Entry 0 is always the head; entry 1 shifts down on a pop.
module fru_fifo2 #(
  parameter int unsigned W = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] ent0_q, ent0_d;
  logic [W-1:0] ent1_q, ent1_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         do_push;
  logic         do_pop;

  // Next-state for storage and occupancy; flush wins over push/pop.
  always_comb begin
    do_pop  = pop_i && (cnt_q != 2'd0);
    do_push = push_i && ((cnt_q != 2'd2) || do_pop);
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    if (do_pop) begin
      ent0_d = ent1_q;
    end
    if (do_push) begin
      if ((cnt_q == 2'd0) || ((cnt_q == 2'd1) && do_pop)) begin
        ent0_d = data_i;
      end else begin
        ent1_d = data_i;
      end
    end
    cnt_d = cnt_q + 2'(do_push) - 2'(do_pop);
    if (flush_i) begin
      cnt_d = 2'd0;
    end
  end

  // Storage and occupancy registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ent0_q <= '0;
      ent1_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      cnt_q  <= cnt_d;
    end
  end

  assign valid_o = (cnt_q != 2'd0);
  assign data_o  = ent0_q;
  assign count_o = cnt_q;

endmodule

// File: rtl/fetch_redirect_unit.sv
// Fetch redirect unit: holds the PC, issues in-order imem requests under a credit
// limit, buffers returned instructions for decode and squashes work on a redirect.
// Optional feature macro: FRU_REDIR_COUNT_EN (adds a saturating redirect counter port).
module fetch_redirect_unit
  import rv_core_pkg::*;
#(
  parameter int unsigned    XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned    DEPTH    = 2
) (
  input  logic               FRU_CLOCK_50,
  input  logic               FRU_RESET_InLow,
  input  logic               FRU_Redir_Valid,
  input  logic [XLEN-1:0]    FRU_Redir_Target,
  output logic               FRU_Imem_Req_Valid,
  input  logic               FRU_Imem_Req_Ready,
  output logic [XLEN-1:0]    FRU_Imem_Req_Addr,
  input  logic               FRU_Imem_Rsp_Valid,
  input  logic [RV_ILEN-1:0] FRU_Imem_Rsp_Data,
  output logic               FRU_Inst_Valid,
  input  logic               FRU_Inst_Ready,
  output logic [RV_ILEN-1:0] FRU_Inst_Data,
  output logic [XLEN-1:0]    FRU_Inst_Pc
`ifdef FRU_REDIR_COUNT_EN
  ,
  output logic [31:0]        FRU_Redir_Count
`endif
);

  localparam int unsigned BUF_W = RV_ILEN + XLEN;

  fru_state_e        state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [1:0]        stale_q, stale_d;
  logic [1:0]        out_cnt;
  logic [1:0]        out_next;
  logic [1:0]        buf_cnt;
  logic              infl_valid;
  logic [XLEN-1:0]   infl_pc;
  logic              req_valid_c;
  logic              req_fire;
  logic              rsp_fire;
  logic              buf_push;
  logic              buf_pop;
  logic              buf_valid;
  logic [BUF_W-1:0]  buf_head;

  // PCs of accepted requests, popped as their responses return.
  fru_fifo2 #(.W(XLEN)) u_inflight (
    .clk_i   (FRU_CLOCK_50),
    .rst_ni  (FRU_RESET_InLow),
    .flush_i (1'b0),
    .push_i  (req_fire),
    .data_i  (pc_q),
    .pop_i   (rsp_fire),
    .valid_o (infl_valid),
    .data_o  (infl_pc),
    .count_o (out_cnt)
  );

  // Instruction buffer towards decode, {pc, instruction} per entry.
  fru_fifo2 #(.W(BUF_W)) u_ibuf (
    .clk_i   (FRU_CLOCK_50),
    .rst_ni  (FRU_RESET_InLow),
    .flush_i (FRU_Redir_Valid),
    .push_i  (buf_push),
    .data_i  ({infl_pc, FRU_Imem_Rsp_Data}),
    .pop_i   (buf_pop),
    .valid_o (buf_valid),
    .data_o  (buf_head),
    .count_o (buf_cnt)
  );

  // Handshakes, PC and stale-response bookkeeping; redirect overrides everything.
  always_comb begin
    req_fire = req_valid_c && FRU_Imem_Req_Ready;
    rsp_fire = FRU_Imem_Rsp_Valid && infl_valid;
    out_next = out_cnt + 2'(req_fire) - 2'(rsp_fire);
    buf_push = rsp_fire && (stale_q == 2'd0) && !FRU_Redir_Valid;
    buf_pop  = buf_valid && FRU_Inst_Ready && !FRU_Redir_Valid;

    pc_d = pc_q;
    if (FRU_Redir_Valid) begin
      pc_d = FRU_Redir_Target;
    end else if (req_fire) begin
      pc_d = pc_q + XLEN'(RV_PC_STEP);
    end

    stale_d = stale_q;
    if (FRU_Redir_Valid && (state_q != ST_FLUSH)) begin
      stale_d = out_next;
    end else if (rsp_fire && (stale_q != 2'd0)) begin
      stale_d = stale_q - 2'd1;
    end
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_BOOT:  state_d = ST_FETCH;
      ST_FETCH: if (FRU_Redir_Valid && (out_next != 2'd0)) state_d = ST_FLUSH;
      ST_FLUSH: if (stale_d == 2'd0) state_d = ST_FETCH;
      default:  state_d = ST_BOOT;
    endcase
  end

  // FSM outputs: issue only while fetching and a buffer slot is reserved.
  always_comb begin
    req_valid_c = (state_q == ST_FETCH) &&
                  ((3'({1'b0, out_cnt}) + 3'({1'b0, buf_cnt})) < 3'(DEPTH));
  end

  // State, PC and stale-count registers.
  always_ff @(posedge FRU_CLOCK_50 or negedge FRU_RESET_InLow) begin
    if (!FRU_RESET_InLow) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      stale_q <= 2'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      stale_q <= stale_d;
    end
  end

  assign FRU_Imem_Req_Valid = req_valid_c;
  assign FRU_Imem_Req_Addr  = pc_q;
  assign FRU_Inst_Valid     = buf_valid;
  assign FRU_Inst_Pc        = buf_head[BUF_W-1:RV_ILEN];
  assign FRU_Inst_Data      = buf_head[RV_ILEN-1:0];

  // A response with nothing in flight is an imem protocol violation.
  a_rsp_has_request : assert property (@(posedge FRU_CLOCK_50) disable iff (!FRU_RESET_InLow)
    !(FRU_Imem_Rsp_Valid && !infl_valid));

`ifdef FRU_REDIR_COUNT_EN
  logic [31:0] redir_cnt_q, redir_cnt_d;

  // Saturating count of redirect cycles.
  always_comb begin
    redir_cnt_d = redir_cnt_q;
    if (FRU_Redir_Valid && (redir_cnt_q != 32'hFFFF_FFFF)) begin
      redir_cnt_d = redir_cnt_q + 32'd1;
    end
  end

  // Redirect counter register.
  always_ff @(posedge FRU_CLOCK_50 or negedge FRU_RESET_InLow) begin
    if (!FRU_RESET_InLow) begin
      redir_cnt_q <= 32'd0;
    end else begin
      redir_cnt_q <= redir_cnt_d;
    end
  end

  assign FRU_Redir_Count = redir_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Bench for fetch_redirect_unit: imem model with random latency, scoreboard of the
// expected decode stream and fetch-address sequence, plus directed corner cases.
module tb_fetch_redirect_unit;
  import rv_core_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        redir_valid;
  logic [31:0] redir_target;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
`ifdef FRU_REDIR_COUNT_EN
  logic [31:0] redir_count;
`endif

  fetch_redirect_unit dut (
    .FRU_CLOCK_50       (clk),
    .FRU_RESET_InLow    (rst_n),
    .FRU_Redir_Valid    (redir_valid),
    .FRU_Redir_Target   (redir_target),
    .FRU_Imem_Req_Valid (req_valid),
    .FRU_Imem_Req_Ready (req_ready),
    .FRU_Imem_Req_Addr  (req_addr),
    .FRU_Imem_Rsp_Valid (rsp_valid),
    .FRU_Imem_Rsp_Data  (rsp_data),
    .FRU_Inst_Valid     (inst_valid),
    .FRU_Inst_Ready     (inst_ready),
    .FRU_Inst_Data      (inst_data),
    .FRU_Inst_Pc        (inst_pc)
`ifdef FRU_REDIR_COUNT_EN
    ,
    .FRU_Redir_Count    (redir_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  int unsigned cyc   = 0;
  int unsigned lat_min = 1;
  int unsigned lat_max = 1;
  int unsigned acc_cnt = 0;
  int unsigned pop_cnt = 0;

  always @(posedge clk) cyc++;

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Instruction memory: in-order responses, random latency, shares the reset.
  logic [31:0] imem_addr_q[$];
  int unsigned imem_due_q[$];
  int unsigned last_due = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      imem_addr_q.delete();
      imem_due_q.delete();
      last_due = 0;
    end else begin
      if (rsp_valid) begin
        void'(imem_addr_q.pop_front());
        void'(imem_due_q.pop_front());
      end
      if (req_valid && req_ready) begin
        int unsigned due;
        due = cyc + 1 + $urandom_range(lat_max, lat_min);
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        imem_addr_q.push_back(req_addr);
        imem_due_q.push_back(due);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rst_n && (imem_due_q.size() > 0) && (imem_due_q[0] <= cyc + 1)) begin
      rsp_valid = 1'b1;
      rsp_data  = imem_word(imem_addr_q[0]);
    end else begin
      rsp_valid = 1'b0;
      rsp_data  = $urandom;
    end
  end

  // Reference model: next fetch address and the queue of PCs owed to decode.
  logic [31:0] exp_pc = 32'h0;
  logic [31:0] sb_q[$];
  logic        hold_pend = 1'b0;
  logic [31:0] hold_addr = 32'h0;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_pc = 32'h0;
      sb_q.delete();
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        check1("hold_valid", req_valid, 1'b1);
        check32("hold_addr", req_addr, hold_addr);
      end
      hold_pend = req_valid && !req_ready && !redir_valid;
      hold_addr = req_addr;
      if (req_valid) check32("req_addr", req_addr, exp_pc);
      if (inst_valid && inst_ready && !redir_valid) begin
        pop_cnt++;
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL inst_unexpected: got pc %h want none (t=%0t)", inst_pc, $time);
        end else begin
          logic [31:0] p;
          p = sb_q.pop_front();
          check32("inst_pc", inst_pc, p);
          check32("inst_data", inst_data, imem_word(p));
        end
      end
      if (req_valid && req_ready) begin
        acc_cnt++;
        sb_q.push_back(exp_pc);
        exp_pc = exp_pc + 32'd4;
      end
      if (redir_valid) begin
        sb_q.delete();
        exp_pc = redir_target;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    redir_valid = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
  endtask

  task automatic wait_req(input string name);
    int n;
    n = 0;
    while (!req_valid && n < 50) begin step(); n++; end
    if (!req_valid) begin
      total++;
      bad++;
      $display("FAIL %s: got req_valid=0 want 1 within 50 cycles", name);
    end
  endtask

  task automatic wait_inst(input string name);
    int n;
    n = 0;
    while (!inst_valid && n < 50) begin step(); n++; end
    if (!inst_valid) begin
      total++;
      bad++;
      $display("FAIL %s: got inst_valid=0 want 1 within 50 cycles", name);
    end
  endtask

  task automatic wait_two_outstanding(input string name);
    int n;
    n = 0;
    while (imem_addr_q.size() != 2 && n < 50) begin step(); n++; end
    check32(name, 32'(imem_addr_q.size()), 32'd2);
  endtask

  task automatic redirect(input logic [31:0] t);
    redir_valid  = 1'b1;
    redir_target = t;
    step();
    redir_valid  = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int unsigned a0;
    int unsigned p0;
    logic        found;
    rst_n        = 1'b0;
    redir_valid  = 1'b0;
    redir_target = 32'h0;
    req_ready    = 1'b1;
    inst_ready   = 1'b1;
    rsp_valid    = 1'b0;
    rsp_data     = 32'h0;

    // Reset values
    #1;
    check1("rst_req_valid", req_valid, 1'b0);
    check32("rst_req_addr", req_addr, 32'h0);
    check1("rst_inst_valid", inst_valid, 1'b0);
    check32("rst_inst_data", inst_data, 32'h0);
    check32("rst_inst_pc", inst_pc, 32'h0);

    // Streaming from reset: first request in the second cycle
    repeat (3) step();
    rst_n = 1'b1;
    @(negedge clk);
    check1("boot_req_valid", req_valid, 1'b0);
    @(negedge clk);
    check1("first_req_valid", req_valid, 1'b1);
    check32("first_req_addr", req_addr, 32'h0);
    p0 = pop_cnt;
    repeat (20) step();
    check1("stream_progress", (pop_cnt - p0) >= 6, 1'b1);

    // Decode stalled: credits cap issue at two, then one per pop
    inst_ready = 1'b0;
    do_reset();
    a0 = acc_cnt;
    repeat (10) step();
    check32("stall_accepts", acc_cnt - a0, 32'd2);
    check1("stall_req_valid", req_valid, 1'b0);
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    repeat (5) step();
    check32("pop_accepts", acc_cnt - a0, 32'd3);
    check1("pop_req_valid", req_valid, 1'b0);

    // Redirect with two requests in flight
    inst_ready = 1'b1;
    lat_min = 4;
    lat_max = 4;
    do_reset();
    wait_two_outstanding("t3_inflight");
    redirect(32'h0000_0100);
    check1("t3_state_flush", dut.state_q == ST_FLUSH, 1'b1);
    check1("t3_inst_valid", inst_valid, 1'b0);
    wait_req("t3_wait_req");
    check32("t3_req_addr", req_addr, 32'h0000_0100);
    wait_inst("t3_wait_inst");
    check32("t3_inst_pc", inst_pc, 32'h0000_0100);

    // Redirect coinciding with an accept and a response
    lat_min = 1;
    lat_max = 1;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      if (req_valid && rsp_valid) found = 1'b1;
      else step();
    end
    check1("t4_found_slot", found, 1'b1);
    redirect(32'h0000_0200);
    check1("t4_inst_valid", inst_valid, 1'b0);
    check1("t4_state_flush", dut.state_q == ST_FLUSH, 1'b1);
    wait_req("t4_wait_req");
    check32("t4_req_addr", req_addr, 32'h0000_0200);
    wait_inst("t4_wait_inst");
    check32("t4_inst_pc", inst_pc, 32'h0000_0200);

    // PC wrap at the top of the address space
    redirect(32'hFFFF_FFF8);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (req_valid && req_addr == 32'h0) found = 1'b1;
      else step();
    end
    check1("t5_wrap_to_zero", found, 1'b1);

    // Asynchronous reset in the middle of a flush
    lat_min = 4;
    lat_max = 4;
    do_reset();
    wait_two_outstanding("t5_inflight");
    redirect(32'h0000_0300);
    check1("t5_state_flush", dut.state_q == ST_FLUSH, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    check1("arst_req_valid", req_valid, 1'b0);
    check32("arst_req_addr", req_addr, 32'h0);
    check1("arst_inst_valid", inst_valid, 1'b0);
    check32("arst_inst_data", inst_data, 32'h0);
    check32("arst_inst_pc", inst_pc, 32'h0);
    check1("arst_state_boot", dut.state_q == ST_BOOT, 1'b1);
    repeat (3) step();
    rst_n = 1'b1;

`ifdef FRU_REDIR_COUNT_EN
    // Redirect counter and saturation
    do_reset();
    check32("cnt_reset", redir_count, 32'd0);
    for (int i = 0; i < 3; i++) begin
      redirect(32'h0000_0400);
      step();
    end
    check32("cnt_three", redir_count, 32'd3);
    force dut.redir_cnt_q = 32'hFFFF_FFFF;
    step();
    release dut.redir_cnt_q;
    redirect(32'h0000_0500);
    step();
    check32("cnt_saturate", redir_count, 32'hFFFF_FFFF);
`endif

    // Randomized traffic against the scoreboard
    lat_min = 1;
    lat_max = 3;
    p0 = pop_cnt;
    for (int i = 0; i < 2000; i++) begin
      req_ready   = ($urandom_range(0, 3) != 0);
      inst_ready  = ($urandom_range(0, 3) != 0);
      redir_valid = ($urandom_range(0, 11) == 0);
      redir_target = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8
                   : {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
      step();
    end
    redir_valid = 1'b0;
    check1("random_progress", (pop_cnt - p0) > 100, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
